pll_nco_gen: RTL and testbench

PLL_NCO_GEN -- requirements
Module: pll_nco_gen

---
 rtl/pll_nco_pkg.sv | 22 ++
 rtl/pll_nco_chan.sv | 42 ++++
 rtl/pll_nco_gen.sv | 124 ++++++++++++
 tb/tb_pll_nco_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_nco_pkg.sv
// Shared types and limits for the multi-channel NCO clock generator.
package pll_nco_pkg;

   typedef enum logic [1:0] {
      StInit,
      StSettle,
      StLocked,
      StApply
   } nco_state_e;

   localparam int unsigned NUM_CLOCKS_MIN = 1;
   localparam int unsigned NUM_CLOCKS_MAX = 8;
   localparam int unsigned ACC_W_MIN      = 8;
   localparam int unsigned ACC_W_MAX      = 48;
   localparam int unsigned LOCK_DELAY_MIN = 2;

   // Lock counter width; never narrower than one bit.
   function automatic int unsigned CNT_W(input int unsigned delay);
      return (delay < 2) ? 1 : $clog2(delay);
   endfunction

endpackage

// File: rtl/pll_nco_chan.sv
// One NCO channel: phase accumulator with registered carry strobe and MSB square output.
module pll_nco_chan
   import pll_nco_pkg::*;
#(
   parameter int unsigned ACC_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [ACC_W-1:0] i_incr,
   input  logic [ACC_W-1:0] i_phase,
   output logic             o_en,
   output logic             o_sq
);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_incr;
   logic             r_en;
   logic [ACC_W:0]   w_sum;

   assign w_sum = {1'b0, r_acc} + {1'b0, r_incr};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc  <= '0;
         r_incr <= '0;
         r_en   <= 1'b0;
      end else if (i_load) begin
         r_acc  <= i_phase;
         r_incr <= i_incr;
         r_en   <= 1'b0;
      end else begin
         r_acc  <= w_sum[ACC_W-1:0];
         r_en   <= w_sum[ACC_W];
      end
   end

   assign o_en = r_en;
   // A stopped channel (incr=0) reports a quiet square output whatever phase it holds.
   assign o_sq = r_acc[ACC_W-1] & (|r_incr);

endmodule

// File: rtl/pll_nco_gen.sv
// Multi-channel NCO clock generator with a settle/lock FSM and a valid/ready config port.
module pll_nco_gen
   import pll_nco_pkg::*;
#(
   parameter int unsigned NUM_CLOCKS = 3,
   parameter int unsigned ACC_W      = 32,
   parameter int unsigned LOCK_DELAY = 1024
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [2:0]            cfg_sel,
   input  logic [ACC_W-1:0]      cfg_incr,
   input  logic [ACC_W-1:0]      cfg_phase,
   output logic [NUM_CLOCKS-1:0] outclk_en,
   output logic [NUM_CLOCKS-1:0] outclk_sq,
   output logic                  locked
);

   localparam int unsigned   CW      = CNT_W(LOCK_DELAY);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_DELAY - 1);

   if (NUM_CLOCKS < NUM_CLOCKS_MIN || NUM_CLOCKS > NUM_CLOCKS_MAX ||
       ACC_W < ACC_W_MIN || ACC_W > ACC_W_MAX || LOCK_DELAY < LOCK_DELAY_MIN) begin : g_param_err
      $error("pll_nco_gen: parameter out of legal range");
   end

   nco_state_e       r_state;
   nco_state_e       w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_next;
   logic [2:0]       r_sel;
   logic [ACC_W-1:0] r_incr;
   logic [ACC_W-1:0] r_phase;
   logic             w_sel_ok;
   logic             w_capture;

   assign w_sel_ok = (32'(cfg_sel) < NUM_CLOCKS);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      cfg_ready    = 1'b0;
      unique case (r_state)
         StInit: begin
            w_state_next = StSettle;
            w_cnt_next   = '0;
         end
         StSettle: begin
            cfg_ready = 1'b1;
            // A config arriving on the terminal count takes priority over locking.
            if (cfg_valid && w_sel_ok) begin
               w_capture    = 1'b1;
               w_state_next = StApply;
            end else if (r_cnt == CNT_MAX) begin
               w_state_next = StLocked;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         StLocked: begin
            cfg_ready = 1'b1;
            if (cfg_valid && w_sel_ok) begin
               w_capture    = 1'b1;
               w_state_next = StApply;
            end
         end
         StApply: begin
            w_state_next = StSettle;
            w_cnt_next   = '0;
         end
         default: begin
            w_state_next = StInit;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state <= StInit;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Out-of-range selects are accepted but never captured, so r_sel is always a real channel.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_sel   <= '0;
         r_incr  <= '0;
         r_phase <= '0;
      end else if (w_capture) begin
         r_sel   <= cfg_sel;
         r_incr  <= cfg_incr;
         r_phase <= cfg_phase;
      end
   end

   assign locked = (r_state == StLocked);

   for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
      logic w_load;

      assign w_load = (r_state == StApply) && (r_sel == 3'(g));

      pll_nco_chan #(
         .ACC_W (ACC_W)
      ) u_chan (
         .i_clk   (refclk),
         .i_rst   (rst),
         .i_load  (w_load),
         .i_incr  (r_incr),
         .i_phase (r_phase),
         .o_en    (outclk_en[g]),
         .o_sq    (outclk_sq[g])
      );
   end

endmodule

// File: tb/tb_pll_nco_gen.sv
// Randomized self-checking bench for pll_nco_gen against a cycle-level arithmetic model.
module tb_pll_nco_gen;

   localparam int NCH = 3;
   localparam int AW  = 8;
   localparam int LD  = 16;
   localparam int MOD = 1 << AW;

   logic           refclk = 1'b0;
   logic           rst;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [2:0]     cfg_sel;
   logic [AW-1:0]  cfg_incr;
   logic [AW-1:0]  cfg_phase;
   logic [NCH-1:0] outclk_en;
   logic [NCH-1:0] outclk_sq;
   logic           locked;

   always #5 refclk = ~refclk;

   pll_nco_gen #(
      .NUM_CLOCKS (NCH),
      .ACC_W      (AW),
      .LOCK_DELAY (LD)
   ) u_dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_sel   (cfg_sel),
      .cfg_incr  (cfg_incr),
      .cfg_phase (cfg_phase),
      .outclk_en (outclk_en),
      .outclk_sq (outclk_sq),
      .locked    (locked)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: per-channel phase/increment as plain integers, plus
   // "cycles since settling began" for the lock decision.
   int m_acc [NCH];
   int m_inc [NCH];
   bit m_en  [NCH];
   bit m_init;
   bit m_apply;
   int m_since;
   int m_sel;
   int m_cinc;
   int m_cph;
   int en_cnt [NCH];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_locked();
      return !m_init && !m_apply && (m_since >= LD);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = 0;
         m_inc[i] = 0;
         m_en[i]  = 1'b0;
      end
      m_init  = 1'b1;
      m_apply = 1'b0;
      m_since = 0;
      m_sel   = 0;
      m_cinc  = 0;
      m_cph   = 0;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < NCH; i++) begin
         int s;
         if (m_apply && m_sel == i) begin
            m_acc[i] = m_cph;
            m_inc[i] = m_cinc;
            m_en[i]  = 1'b0;
         end else begin
            s        = m_acc[i] + m_inc[i];
            m_en[i]  = (s >= MOD);
            m_acc[i] = s % MOD;
         end
      end
      if (m_init) begin
         m_init  = 1'b0;
         m_since = 0;
      end else if (m_apply) begin
         m_apply = 1'b0;
         m_since = 0;
      end else if (cfg_valid && int'(cfg_sel) < NCH) begin
         m_apply = 1'b1;
         m_sel   = int'(cfg_sel);
         m_cinc  = int'(cfg_incr);
         m_cph   = int'(cfg_phase);
      end else if (m_since < 100000) begin
         m_since++;
      end
   endtask

   task automatic compare_all();
      logic [NCH-1:0] e_en;
      logic [NCH-1:0] e_sq;
      for (int i = 0; i < NCH; i++) begin
         e_en[i] = m_en[i];
         e_sq[i] = (m_inc[i] != 0) && (m_acc[i] >= MOD / 2);
         if (outclk_en[i]) en_cnt[i]++;
      end
      check_eq("outclk_en", 32'(outclk_en), 32'(e_en));
      check_eq("outclk_sq", 32'(outclk_sq), 32'(e_sq));
      check_eq("locked", 32'(locked), 32'(m_locked()));
      check_eq("cfg_ready", 32'(cfg_ready), 32'(!m_init && !m_apply));
   endtask

   task automatic step();
      @(posedge refclk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clear_counts();
      for (int i = 0; i < NCH; i++) en_cnt[i] = 0;
   endtask

   task automatic send_cfg(input int sel, input int inc, input int ph);
      cfg_valid = 1'b1;
      cfg_sel   = 3'(sel);
      cfg_incr  = AW'(inc);
      cfg_phase = AW'(ph);
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_locked();
      for (int k = 0; k < 100 && !locked; k++) step();
      check_eq("lock_wait", 32'(locked), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_sel   = '0;
      cfg_incr  = '0;
      cfg_phase = '0;
      model_reset();
      clear_counts();
      run(3);
      check_eq("rst_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b0;

      // Reset release with no config: lock appears on the 17th edge.
      for (int k = 1; k <= 17; k++) begin
         step();
         if (k == 1)  check_eq("ready_after_init", 32'(cfg_ready), 32'd1);
         if (k == 16) check_eq("lock_c16", 32'(locked), 32'd0);
         if (k == 17) begin
            check_eq("lock_c17", 32'(locked), 32'd1);
            check_eq("idle_en", 32'(outclk_en), 32'd0);
            check_eq("idle_sq", 32'(outclk_sq), 32'd0);
         end
      end

      // Channel 0 at incr=64: one strobe every 4 cycles.
      send_cfg(0, 64, 0);
      check_eq("lock_drop", 32'(locked), 32'd0);
      step();
      clear_counts();
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 15) check_eq("relock_15", 32'(locked), 32'd0);
         if (k == 16) check_eq("relock_16", 32'(locked), 32'd1);
      end
      run(24);
      check_eq("ch0_pulses", 32'(en_cnt[0]), 32'd10);

      // Channel 1 at incr=3: non-integer period, 3 wraps in 258 cycles.
      send_cfg(1, 3, 0);
      step();
      clear_counts();
      run(258);
      check_eq("ch1_wraps", 32'(en_cnt[1]), 32'd3);

      // Second config at settle count 10 restarts the lock count.
      wait_locked();
      send_cfg(2, 17, 5);
      step();
      run(10);
      send_cfg(0, 32, 100);
      check_eq("second_cfg_ready", 32'(cfg_ready), 32'd0);
      step();
      for (int k = 1; k <= 16; k++) begin
         step();
         if (k == 15) check_eq("relock2_15", 32'(locked), 32'd0);
         if (k == 16) check_eq("relock2_16", 32'(locked), 32'd1);
      end

      // Config on the terminal count wins over locking.
      send_cfg(1, 5, 0);
      step();
      run(15);
      send_cfg(2, 9, 9);
      check_eq("term_cfg_wins", 32'(locked), 32'd0);
      wait_locked();

      // Out-of-range select is swallowed without losing lock.
      send_cfg(5, 99, 1);
      check_eq("bad_sel_locked", 32'(locked), 32'd1);
      run(20);

      // Reset in the middle of APPLY leaves nothing behind.
      send_cfg(2, 200, 128);
      #1;
      rst = 1'b1;
      #1;
      check_eq("rst_apply_en", 32'(outclk_en), 32'd0);
      check_eq("rst_apply_sq", 32'(outclk_sq), 32'd0);
      check_eq("rst_apply_locked", 32'(locked), 32'd0);
      check_eq("rst_apply_ready", 32'(cfg_ready), 32'd0);
      model_reset();
      run(2);
      rst = 1'b0;
      clear_counts();
      run(40);
      check_eq("post_rst_ch2_en", 32'(en_cnt[2]), 32'd0);

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         cfg_valid = ($urandom_range(0, 9) == 0);
         cfg_sel   = 3'($urandom_range(0, 7) < 6 ? $urandom_range(0, NCH - 1) : $urandom_range(3, 7));
         cfg_incr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
         cfg_phase = AW'($urandom);
         step();
      end
      cfg_valid = 1'b0;
      run(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
